// File: rtl/onehot_sticky_tracker.sv
// Sticky one-hot coverage accumulator with popcount, done flag, error pulses and round counter.
// Define ONEHOT_DUP_ERR_EN to flag legal hits that land on an already-set bit.
module onehot_sticky_tracker #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH + 1),
  parameter int ERR_W = 8,
  parameter int RND_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     clear,
  output logic [WIDTH-1:0]         latched,
  output logic [CNT_W-1:0]         count,
  output logic [$clog2(WIDTH)-1:0] last_idx,
  output logic                     done,
  output logic                     err_multi,
  output logic                     dup_err,
  output logic [ERR_W-1:0]         err_cnt,
  output logic [RND_W-1:0]         rounds
);

  localparam int LIDX_W = $clog2(WIDTH);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

  state_t state, state_next;

  logic              legal;
  logic              hit_new;
  logic              take;
  logic              bad;
  logic              dup;
  logic [LIDX_W-1:0] hit_idx;

  function automatic logic [LIDX_W-1:0] onehot_index(input logic [WIDTH-1:0] v);
    logic [LIDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) idx = LIDX_W'(i);
    end
    return idx;
  endfunction

  assign legal   = (|in_data) && !(|(in_data & (in_data - WIDTH'(1))));
  assign hit_new = |(in_data & ~latched);
  assign hit_idx = onehot_index(in_data);

  // clear suppresses both accepts and error reporting for the same cycle
  assign take = in_valid && in_ready && legal && !clear;
  assign bad  = in_valid && in_ready && !legal && !clear;

`ifdef ONEHOT_DUP_ERR_EN
  assign dup = take && !hit_new;
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (take) state_next = FILLING;
      FILLING: if (take && hit_new && count == CNT_W'(WIDTH - 1)) state_next = FULL;
      FULL:    state_next = FULL;
      default: state_next = EMPTY;
    endcase
    if (clear) state_next = EMPTY;
  end

  always_comb begin
    in_ready = (state != FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latched   <= '0;
      count     <= '0;
      last_idx  <= '0;
      done      <= 1'b0;
      err_multi <= 1'b0;
      dup_err   <= 1'b0;
      err_cnt   <= '0;
      rounds    <= '0;
    end else begin
      err_multi <= bad;
      dup_err   <= dup;
      done      <= (state_next == FULL);
      if ((bad || dup) && err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
      if (state != FULL && state_next == FULL) rounds <= rounds + RND_W'(1);
      if (clear) begin
        latched  <= '0;
        count    <= '0;
        last_idx <= '0;
      end else if (take) begin
        latched  <= latched | in_data;
        last_idx <= hit_idx;
        if (hit_new) count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/onehot_sticky_tracker.md
# onehot_sticky_tracker

Parametrised sticky one-hot accumulator for property-check and coverage harnesses. It accepts one-hot hit vectors over a valid/ready handshake and ORs each legal hit into a WIDTH-bit sticky vector. It maintains a population count and raises `done` once every bit has been hit. It adds malformed-input detection, synchronous clear/restart and a completed-round counter, so one instance can track repeated coverage epochs.

## Interface
- `WIDTH`, 64: number of tracked bits; legal range is 2 or more.
- `CNT_W`, `$clog2(WIDTH+1)`: derived width of the population count.
- `ERR_W`, 8: width of the saturating error counter.
- `RND_W`, 8: width of the wrapping round counter.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: hit vector present.
- `in_ready` out 1: block can accept a hit.
- `in_data` in WIDTH: hit vector; must be one-hot to be accepted.
- `clear` in 1: synchronous restart of the current round.
- `latched` out WIDTH: sticky hit vector.
- `count` out CNT_W: number of ones in `latched`.
- `last_idx` out `$clog2(WIDTH)`: index of the most recently accepted hit.
- `done` out 1: all WIDTH bits set.
- `err_multi` out 1: one-cycle pulse on a zero or multi-hot vector.
- `dup_err` out 1: one-cycle pulse on a hit to an already-set bit (macro-gated).
- `err_cnt` out ERR_W: saturating count of error pulses.
- `rounds` out RND_W: number of completed rounds, wrapping.

## Operation
- States:
  - EMPTY: `latched` == 0.
  - FILLING: 0 < `count` < WIDTH.
  - FULL: `count` == WIDTH.
- `in_ready` = (state != FULL).
- Legal vector: `in_data != 0 && (in_data & (in_data-1)) == 0`.
- Accept = `in_valid && in_ready && legal`. On accept:
  - `latched |= in_data`.
  - `last_idx` = index of the set bit.
  - `count` increments only if that bit was previously 0.
- Transitions:
  - EMPTY→FILLING on first accept.
  - FILLING→FULL when an accept sets the last zero bit.
  - When WIDTH bits are covered, EMPTY→FULL is impossible; the path always passes through FILLING.
- On entry to FULL, `rounds` increments by one, wrapping modulo 2^RND_W.
- FULL holds until `clear`. While FULL, `in_valid` is ignored: no error, no update.
- `in_valid && !legal && in_ready`:
  - Pulse `err_multi`.
  - Leave `latched`, `count` and `last_idx` unchanged.
- `clear`:
  - Next state EMPTY; `latched`, `count` and `last_idx` go to 0.
  - `rounds` and `err_cnt` are retained.
  - `clear` wins over a same-cycle accept; that hit is dropped with no error.
- `err_cnt` adds 1 per error pulse, saturating at 2^ERR_W-1. It is cleared only by `rst`.

## Timing
- Reset values:
  - `latched`, `count`, `last_idx`, `done`, `err_multi`, `dup_err`, `err_cnt` and `rounds` are all 0.
  - `in_ready` is 1; state is EMPTY.
- All outputs except `in_ready` are registered.
- A hit accepted at edge N is visible on `latched`, `count` and `last_idx` after edge N.
- `done` and the `rounds` increment appear at the same edge as the final bit.
- `in_ready` is combinational from state. It drops the cycle after the final hit is accepted, so no hit is lost.
- `err_multi` and `dup_err` are high for exactly one cycle after the offending edge.
- `rst` asserted mid-round forces reset values immediately and asynchronously. Deassertion is taken synchronously to `clk`.

## Configuration
- `ONEHOT_DUP_ERR_EN` defined:
  - A legal accept to an already-set bit pulses `dup_err` and increments `err_cnt`.
  - `latched` and `count` are unchanged; `last_idx` updates.
- Not defined: `dup_err` is tied 0 and duplicate hits are silent, with `last_idx` still updating.

## Test plan
- WIDTH=8: hits `0x01`, `0x02`, … `0x80` on consecutive cycles.
  - `count` steps 1..8; `done`=1 and `rounds`=1 after the 8th edge.
  - `in_ready`=0 the following cycle.
- WIDTH=8: `in_data`=`0x03`, then `0x00`, with `in_valid`=1.
  - `err_multi` pulses twice; `err_cnt`=2; `latched`=0.
- Macro on, WIDTH=8: hit `0x04` twice.
  - Second hit gives `dup_err` pulse; `count`=1; `err_cnt`=1.
  - Macro off: no pulse; `err_cnt`=0.
- WIDTH=8, FULL state, `clear`=1 together with hit `0x10`.
  - Next cycle `latched`=0, `count`=0, `done`=0, `rounds`=1; hit dropped.
- `rst` pulsed while `count`=5: all outputs 0 before the next clock edge; `in_ready`=1.
- ERR_W=2: five illegal vectors give `err_cnt` saturated at 3.
